// File: rtl/rr_multi_grant_arbiter.sv
// rr_multi_grant_arbiter: round-robin arbiter granting up to NUM_GNT of
// NUM_REQ requesters per cycle, with stall and a registered grant output.
//
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous active-high reset
//   req_in      request vector, bit i = requester i
//   valid       req_in is valid, arbitrate this cycle
//   stall_in    downstream busy, hold grant_out and pointer
//   grant_out   registered grant vector (one bit per winner)
//   grant_valid registered, equals |grant_out
//   ptr_out     current highest-priority index
//
// Build option: ARB_FIXED_ROTATE_EN selects the legacy rotating pointer
// (ptr+1 on every arbitration) instead of last-winner-plus-one.
module rr_multi_grant_arbiter #(
    parameter int NUM_REQ = 8,
    parameter int NUM_GNT = 2,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_in,
    input  logic               valid,
    input  logic               stall_in,
    output logic [NUM_REQ-1:0] grant_out,
    output logic               grant_valid,
    output logic [PTR_W-1:0]   ptr_out
);

    localparam int IDX_W = PTR_W + 1;
    localparam int CNT_W = $clog2(NUM_REQ + 1) + 1;

    localparam logic [IDX_W-1:0] N_IDX    = IDX_W'(NUM_REQ);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] GNT_LIM  = CNT_W'(NUM_GNT);

    logic [PTR_W-1:0]   ptr_q;
    logic [PTR_W-1:0]   ptr_nxt;
    logic [NUM_REQ-1:0] gnt_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [IDX_W-1:0]   idx;
`ifndef ARB_FIXED_ROTATE_EN
    logic [PTR_W-1:0]   last_win;
    logic               any_win;
`endif

    // Wrapping increment; never produces an index >= NUM_REQ.
    function automatic logic [PTR_W-1:0] ptr_inc(
        input logic [PTR_W-1:0] p
    );
        return (p == LAST_IDX) ? '0 : p + PTR_W'(1);
    endfunction

    // Walk requesters in scan order starting at ptr_q and take the
    // first NUM_GNT that are requesting.
    always_comb begin
        gnt_nxt = '0;
        cnt     = '0;
        idx     = '0;
`ifndef ARB_FIXED_ROTATE_EN
        last_win = ptr_q;
        any_win  = 1'b0;
`endif
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = {1'b0, ptr_q} + IDX_W'(i);
            if (idx >= N_IDX) begin
                idx = idx - N_IDX;
            end
            if (req_in[idx[PTR_W-1:0]] && (cnt < GNT_LIM)) begin
                gnt_nxt[idx[PTR_W-1:0]] = 1'b1;
                cnt = cnt + CNT_W'(1);
`ifndef ARB_FIXED_ROTATE_EN
                last_win = idx[PTR_W-1:0];
                any_win  = 1'b1;
`endif
            end
        end
    end

`ifdef ARB_FIXED_ROTATE_EN
    assign ptr_nxt = ptr_inc(ptr_q);
`else
    // Resume just after the last winner; hold if nothing was granted.
    assign ptr_nxt = any_win ? ptr_inc(last_win) : ptr_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_out   <= '0;
            grant_valid <= 1'b0;
            ptr_q       <= '0;
        end else if (stall_in) begin
            grant_out   <= grant_out;
            grant_valid <= grant_valid;
            ptr_q       <= ptr_q;
        end else if (valid) begin
            grant_out   <= gnt_nxt;
            grant_valid <= |gnt_nxt;
            ptr_q       <= ptr_nxt;
        end else begin
            grant_out   <= '0;
            grant_valid <= 1'b0;
        end
    end

    assign ptr_out = ptr_q;

endmodule

// File: tb/tb_rr_multi_grant_arbiter.sv
// tb_rr_multi_grant_arbiter: directed and randomized checks of
// rr_multi_grant_arbiter against a distance-ranking reference model.
module tb_rr_multi_grant_arbiter;

    localparam int N  = 8;
    localparam int G  = 2;
    localparam int PW = $clog2(N);
    localparam int BOUND = (N - 1 + G - 1) / G;

    logic          clk;
    logic          rst;
    logic [N-1:0]  req_in;
    logic          valid;
    logic          stall_in;
    logic [N-1:0]  grant_out;
    logic          grant_valid;
    logic [PW-1:0] ptr_out;

    int n_checks;
    int n_pass;

    int           m_ptr;
    logic [N-1:0] m_gnt;
    int           waits [N];

    rr_multi_grant_arbiter #(
        .NUM_REQ(N),
        .NUM_GNT(G)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_in     (req_in),
        .valid      (valid),
        .stall_in   (stall_in),
        .grant_out  (grant_out),
        .grant_valid(grant_valid),
        .ptr_out    (ptr_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Requester i ranks by its distance from ptr in scan order; it wins
    // when fewer than G requesters are closer. New ptr follows the
    // farthest winner.
    function automatic void arb_ref(input logic [N-1:0] r, input int p,
                                    output logic [N-1:0] g,
                                    output int np);
        int maxd;
        int last;
        g = '0;
        maxd = -1;
        last = 0;
        for (int i = 0; i < N; i++) begin
            if (r[i]) begin
                int d;
                int ahead;
                d = (i - p + N) % N;
                ahead = 0;
                for (int j = 0; j < N; j++)
                    if (r[j] && ((j - p + N) % N) < d) ahead++;
                if (ahead < G) begin
                    g[i] = 1'b1;
                    if (d > maxd) begin
                        maxd = d;
                        last = i;
                    end
                end
            end
        end
        np = (maxd >= 0) ? (last + 1) % N : p;
    endfunction

    task automatic model_reset();
        m_ptr = 0;
        m_gnt = '0;
        for (int i = 0; i < N; i++) waits[i] = 0;
    endtask

    task automatic model_step();
        logic [N-1:0] g;
        int np;
        if (stall_in) begin
            for (int i = 0; i < N; i++) if (!req_in[i]) waits[i] = 0;
        end else if (valid) begin
            arb_ref(req_in, m_ptr, g, np);
`ifdef ARB_FIXED_ROTATE_EN
            np = (m_ptr + 1) % N;
`else
            for (int i = 0; i < N; i++) begin
                if (g[i]) begin
                    check("starve", 32'(waits[i] <= BOUND), 32'd1);
                    waits[i] = 0;
                end else if (req_in[i]) begin
                    waits[i]++;
                end else begin
                    waits[i] = 0;
                end
            end
`endif
            m_gnt = g;
            m_ptr = np;
        end else begin
            m_gnt = '0;
            for (int i = 0; i < N; i++) if (!req_in[i]) waits[i] = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("grant", 32'(grant_out), 32'(m_gnt));
        check("gvalid", 32'(grant_valid), 32'(|m_gnt));
        check("ptr", 32'(ptr_out), 32'(m_ptr));
    endtask

    // Assert reset between clock edges and confirm it acts at once.
    task automatic mid_reset();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("rst_grant", 32'(grant_out), 32'd0);
        check("rst_gvalid", 32'(grant_valid), 32'd0);
        check("rst_ptr", 32'(ptr_out), 32'd0);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        req_in   = '0;
        valid    = 1'b0;
        stall_in = 1'b0;
        model_reset();
        #3;
        check("por_grant", 32'(grant_out), 32'd0);
        check("por_gvalid", 32'(grant_valid), 32'd0);
        check("por_ptr", 32'(ptr_out), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

`ifndef ARB_FIXED_ROTATE_EN
        valid  = 1'b1;
        req_in = 8'b1011_0110;
        tick();
        check("seq0", 32'(grant_out), 32'h06);
        check("seq0_ptr", 32'(ptr_out), 32'd3);
        tick();
        check("seq1", 32'(grant_out), 32'h30);
        check("seq1_ptr", 32'(ptr_out), 32'd6);
        tick();
        check("seq2", 32'(grant_out), 32'h82);
        check("seq2_ptr", 32'(ptr_out), 32'd2);
        check("seq2_gv", 32'(grant_valid), 32'd1);
        req_in = 8'b0000_1000;
        tick();
        check("single", 32'(grant_out), 32'h08);
        check("single_ptr", 32'(ptr_out), 32'd4);
        req_in = '0;
        tick();
        check("noreq_gv", 32'(grant_valid), 32'd0);
        check("noreq_ptr", 32'(ptr_out), 32'd4);

        mid_reset();
        req_in = 8'b1011_0110;
        tick();
        stall_in = 1'b1;
        req_in   = 8'hFF;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_grant", 32'(grant_out), 32'h06);
            check("stall_ptr", 32'(ptr_out), 32'd3);
        end
        stall_in = 1'b0;
        tick();
        check("post_stall", 32'(grant_out), 32'h18);
        valid = 1'b0;
        tick();
        check("inv_grant", 32'(grant_out), 32'h00);
        check("inv_ptr", 32'(ptr_out), 32'd5);

        mid_reset();
        valid  = 1'b1;
        req_in = 8'b1011_0110;
        tick();
        tick();
        check("pre_rst", 32'(grant_out), 32'h30);
        mid_reset();
        req_in = 8'hFF;
        tick();
        check("post_rst", 32'(grant_out), 32'h03);
`else
        valid  = 1'b1;
        req_in = 8'b1000_0001;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("rot_grant", 32'(grant_out), 32'h81);
            check("rot_ptr", 32'(ptr_out), 32'((k + 1) % N));
        end
        req_in = '0;
        tick();
        check("rot_empty", 32'(ptr_out), 32'd3);
`endif

        mid_reset();
        for (int c = 0; c < 600; c++) begin
            req_in   = N'($urandom);
            if ($urandom_range(0, 3) == 0) req_in = req_in & N'($urandom);
            valid    = ($urandom_range(0, 9) < 8);
            stall_in = ($urandom_range(0, 9) < 2);
            tick();
            if ($urandom_range(0, 99) == 0) mid_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
